alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (even, >= 8).
REQ-002 The block SHALL have parameter SHW, default 5, meaning shift-amount width, equal to log2(WIDTH).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  request present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port op  input  4  operation code.
REQ-008 The block SHALL have port a  input  WIDTH  operand A; a[SHW-1:0] is the shift amount for shifts.
REQ-009 The block SHALL have port b  input  WIDTH  operand B.
REQ-010 The block SHALL have port out_valid  output  1  result s is valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port s  output  WIDTH  registered result.
REQ-013 The block SHALL have port dz  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-014 Opcodes SHALL be: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 LUI b<<(WIDTH/2); 6 SLL b<<a[SHW-1:0]; 7 SRL logical; 8 SRA arithmetic on b; 9 HAMD popcount(a^b), zero-extended; 10 MUL low WIDTH bits of a*b (unsigned); 11 DIVU quotient; 12 REMU remainder; 13-15 result 0.
REQ-015 Add/sub SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-016 State machine SHALL have states IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a rising edge, and op/a/b are captured.
REQ-018 Ops 0-9 and 13-15 SHALL go IDLE->DONE; s is valid on the edge after acceptance (latency 1).
REQ-019 Ops 10-12 SHALL go IDLE->BUSY and iterate one bit per cycle for exactly WIDTH cycles, then go to DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-020 MUL SHALL be shift-add; DIVU/REMU SHALL be restoring division, unsigned.
REQ-021 Inputs SHALL be ignored while in BUSY or DONE; changes on a/b/op after acceptance SHALL NOT affect the result.
REQ-022 In DONE, out_valid=1 and s/dz SHALL hold stable until out_ready=1, then go to IDLE on that edge; in_ready rises on the following cycle, with no same-cycle reaccept.
REQ-023 Divide by zero (b==0, op 11/12) SHALL produce quotient all-ones, remainder = a, dz=1, with the same latency as a normal division.
REQ-024 dz SHALL be 0 for every non-division result.
REQ-025 Outside DONE, out_valid SHALL be 0; s SHALL retain its last value.

Reset
REQ-026 When reset=1 on a rising edge, the next state SHALL be: IDLE, in_ready=1, out_valid=0, s=0, dz=0, iteration counter 0.
REQ-027 Reset SHALL have priority over all other inputs, including in_valid.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation; the pending result is discarded and never presented.

Configuration
REQ-029 With macro ALU_SEQ_DIV_EN defined, ops 11/12 SHALL behave per REQ-019..REQ-023.
REQ-030 Without ALU_SEQ_DIV_EN, no divider logic SHALL be built; ops 11/12 SHALL take the latency-1 path with s=0 and dz=0; MUL is unaffected.

Verification
REQ-031 WIDTH=32; ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid one cycle after accept, s=0x00000000, dz=0.
REQ-032 SRA a=4 b=0x80000000 -> s=0xF8000000; HAMD a=0xF0F0F0F0 b=0x0F0F0F0F -> s=32; LUI b=0x1234 -> s=0x12340000.
REQ-033 MUL a=0x10001 b=0x10001 -> out_valid exactly 33 cycles after accept, s=0x00020001; in_ready=0 throughout; a new in_valid during BUSY is ignored.
REQ-034 DIVU a=100 b=7 -> s=14; REMU -> s=2; DIVU a=5 b=0 -> s=0xFFFFFFFF, dz=1; without ALU_SEQ_DIV_EN, DIVU a=100 b=7 -> s=0 at latency 1.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> s/out_valid stable; out_ready=1 -> IDLE next edge, in_ready=1 the cycle after.
REQ-036 Reset at cycle 10 of a MUL -> out_valid never rises for it; in_ready=1, s=0 after reset; a following ADD 2+3 -> s=5.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply.
// Define ALU_SEQ_DIV_EN to build the restoring divider for DIVU/REMU (ops 11/12).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_HAMD = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
`endif

  localparam logic [SHW-1:0] iterLast = SHW'(WIDTH - 1);

  stateT            state, nextState;
  logic [SHW-1:0]   iterCnt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [WIDTH-1:0] opaNext, opbNext, accNext;
  logic [WIDTH-1:0] quickResult;
  logic             isIter;
`ifdef ALU_SEQ_DIV_EN
  logic [3:0]       opReg;
  logic [WIDTH:0]   divShift, divDiff;
`endif

  function automatic logic [WIDTH-1:0] popCount(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + WIDTH'(x[i]);
    return c;
  endfunction

  always_comb begin
    isIter = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    if (op == OP_DIVU || op == OP_REMU) isIter = 1'b1;
`endif
  end

  always_comb begin
    quickResult = '0;
    case (op)
      OP_ADD:  quickResult = a + b;
      OP_SUB:  quickResult = a - b;
      OP_AND:  quickResult = a & b;
      OP_OR:   quickResult = a | b;
      OP_XOR:  quickResult = a ^ b;
      OP_LUI:  quickResult = b << (WIDTH / 2);
      OP_SLL:  quickResult = b << a[SHW-1:0];
      OP_SRL:  quickResult = b >> a[SHW-1:0];
      OP_SRA:  quickResult = $unsigned($signed(b) >>> a[SHW-1:0]);
      OP_HAMD: quickResult = popCount(a ^ b);
      default: quickResult = '0;
    endcase
  end

  // One iteration step: multiply consumes opb LSB-first; division shifts the
  // dividend out of opa while the quotient bits shift into its bottom.
  always_comb begin
    accNext = acc;
    opaNext = opa << 1;
    opbNext = opb >> 1;
    if (opb[0]) accNext = acc + opa;
`ifdef ALU_SEQ_DIV_EN
    divShift = {acc, opa[WIDTH-1]};
    divDiff  = divShift - {1'b0, opb};
    if (opReg != OP_MUL) begin
      opbNext = opb;
      if (!divDiff[WIDTH]) begin
        accNext = divDiff[WIDTH-1:0];
        opaNext = {opa[WIDTH-2:0], 1'b1};
      end else begin
        accNext = divShift[WIDTH-1:0];
        opaNext = {opa[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = isIter ? BUSY : DONE;
      end
      BUSY: if (iterCnt == iterLast) nextState = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Result is written on the accept edge for quick ops, on the last iteration otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s       <= '0;
      dz      <= 1'b0;
      iterCnt <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
`ifdef ALU_SEQ_DIV_EN
      opReg   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa     <= a;
          opb     <= b;
          acc     <= '0;
          iterCnt <= '0;
`ifdef ALU_SEQ_DIV_EN
          opReg   <= op;
`endif
          if (!isIter) begin
            s  <= quickResult;
            dz <= 1'b0;
          end
        end
        BUSY: begin
          acc     <= accNext;
          opa     <= opaNext;
          opb     <= opbNext;
          iterCnt <= iterCnt + SHW'(1);
          if (iterCnt == iterLast) begin
`ifdef ALU_SEQ_DIV_EN
            if (opReg == OP_DIVU) begin
              s  <= opaNext;
              dz <= (opb == '0);
            end else if (opReg == OP_REMU) begin
              s  <= accNext;
              dz <= (opb == '0);
            end else begin
              s  <= accNext;
              dz <= 1'b0;
            end
`else
            s  <= accNext;
            dz <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32: directed cases, backpressure,
// abort-by-reset and a short random sweep. Honors ALU_SEQ_DIV_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        dz;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] s;
    logic        dz;
    int          lat;
  } expT;

  expT sbQueue[$];

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the opcode table, using plain operators.
  function automatic expT model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    expT e;
    e.s = '0; e.dz = 1'b0; e.lat = 1;
    case (o)
      4'd0:  e.s = x + y;
      4'd1:  e.s = x - y;
      4'd2:  e.s = x & y;
      4'd3:  e.s = x | y;
      4'd4:  e.s = x ^ y;
      4'd5:  e.s = y << 16;
      4'd6:  e.s = y << x[4:0];
      4'd7:  e.s = y >> x[4:0];
      4'd8:  e.s = $unsigned($signed(y) >>> x[4:0]);
      4'd9:  e.s = 32'($countones(x ^ y));
      4'd10: begin e.s = x * y; e.lat = 33; end
      4'd11: begin
`ifdef ALU_SEQ_DIV_EN
        e.lat = 33;
        if (y == 0) begin e.s = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else e.s = x / y;
`endif
      end
      4'd12: begin
`ifdef ALU_SEQ_DIV_EN
        e.lat = 33;
        if (y == 0) begin e.s = x; e.dz = 1'b1; end
        else e.s = x % y;
`endif
      end
      default: e.s = '0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    int   lat;
    int   waitCnt;
    int   busyReadyErr;
    int   holdErr;
    expT  e;
    logic [31:0] sSeen;
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    sbQueue.push_back(model(o, x, y));
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = (hold == 0);
    @(negedge clk);
    lat = 1;
    busyReadyErr = 0;
    // Junk on the inputs after acceptance must not disturb the result.
    while (!out_valid && lat < 100) begin
      if (in_ready) busyReadyErr++;
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    e = sbQueue.pop_front();
    checkOutput($sformatf("lat_op%0d", o), 32'(lat), 32'(e.lat));
    checkOutput($sformatf("s_op%0d", o), s, e.s);
    checkOutput($sformatf("dz_op%0d", o), 32'(dz), 32'(e.dz));
    if (e.lat > 1) checkOutput("ready_busy", 32'(busyReadyErr), 32'd0);
    checkOutput("ready_done", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      holdErr = 0;
      sSeen = s;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || s !== sSeen || in_ready) holdErr++;
      end
      checkOutput("hold_stable", 32'(holdErr), 32'd0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic abortTest();
    int sawValid;
    in_valid  = 1'b1;
    op        = 4'd10;
    a         = 32'h1234_5678;
    b         = 32'h0000_0FFF;
    out_ready = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 32'd7; b = 32'd9;
    for (int i = 0; i < 9; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_s", s, 32'd0);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) sawValid++;
    end
    checkOutput("abort_never_valid", 32'(sawValid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_s", s, 32'd0);
    checkOutput("rst_dz", 32'(dz), 32'd0);

    applyStimulus(4'd0,  32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'd8,  32'd4, 32'h8000_0000, 0);
    applyStimulus(4'd9,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
    applyStimulus(4'd5,  32'hDEAD_0000, 32'h0000_1234, 0);
    applyStimulus(4'd10, 32'h0001_0001, 32'h0001_0001, 0);
    applyStimulus(4'd11, 32'd100, 32'd7, 0);
    applyStimulus(4'd12, 32'd100, 32'd7, 0);
    applyStimulus(4'd11, 32'd5, 32'd0, 0);
    applyStimulus(4'd12, 32'd5, 32'd0, 0);
    applyStimulus(4'd1,  32'd3, 32'd5, 5);
    applyStimulus(4'd2,  32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    applyStimulus(4'd3,  32'hFF00_0000, 32'h0000_00FF, 0);
    applyStimulus(4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 0);
    applyStimulus(4'd6,  32'd31, 32'd1, 0);
    applyStimulus(4'd7,  32'd4, 32'h8000_0000, 0);
    applyStimulus(4'd14, 32'd1, 32'd2, 0);
    applyStimulus(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

    abortTest();
    applyStimulus(4'd0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 12; i++)
      applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
